alu_exec_unit: RTL and testbench

//  Registered, handshaked execute stage wrapping the 6-op ALU function set. Accepts operation requests
//  (a, b, op, tag) over valid/ready, computes result+flags, buffers responses in a DEPTH-entry FIFO, and

---
 rtl/alu_exec_unit.sv | 139 +++++++++++++
 tb/tb_alu_exec_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Handshaked ALU execute stage: computes add/sub/logic results with flags on accept
// and returns them in order through a DEPTH-entry response FIFO.
module alu_exec_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [2:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_carry,
  output logic             rsp_ovf,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [15:0]      op_count,
  output logic [7:0]       err_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = WIDTH + TAG_W + 4;
  localparam int unsigned MSB   = WIDTH - 1;

  // Entry layout: {err, ovf, carry, zero, tag, result}
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             req_ready_q, req_ready_d;
  logic [15:0]      op_count_q, op_count_d;
  logic [7:0]       err_count_q, err_count_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] res;
  logic             res_zero;
  logic             res_carry;
  logic             res_ovf;
  logic             res_err;
  logic [ENT_W-1:0] entry;
  logic             push;
  logic             pop;

  // ALU function set, evaluated directly on the request operands
  always_comb begin
    sum       = {1'b0, req_a} + {1'b0, req_b};
    diff      = {1'b0, req_a} - {1'b0, req_b};
    res       = '0;
    res_carry = 1'b0;
    res_ovf   = 1'b0;
    res_err   = 1'b0;
    case (req_op)
      3'b000: begin
        res       = sum[WIDTH-1:0];
        res_carry = sum[WIDTH];
        res_ovf   = (req_a[MSB] == req_b[MSB]) && (res[MSB] != req_a[MSB]);
      end
      3'b001: begin
        res       = diff[WIDTH-1:0];
        res_carry = diff[WIDTH];
        res_ovf   = (req_a[MSB] != req_b[MSB]) && (res[MSB] != req_a[MSB]);
      end
      3'b010:  res = req_a & req_b;
      3'b011:  res = req_a | req_b;
      3'b100:  res = req_a ^ req_b;
      3'b101:  res = ~(req_a | req_b);
      default: res_err = 1'b1;
    endcase
    res_zero = (res == '0);
    entry    = {res_err, res_ovf, res_carry, res_zero, req_tag, res};
  end

  assign push = req_valid & req_ready_q;
  assign pop  = rsp_valid_q & rsp_ready;

  // FIFO bookkeeping; ready/valid are recomputed from the next count so both stay registered
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    op_count_d  = op_count_q;
    err_count_d = err_count_q;
    if (push) begin
      mem_d[wr_ptr_q] = entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      if (op_count_q != 16'hFFFF) op_count_d = op_count_q + 16'd1;
      if (res_err && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    rsp_valid_d = (count_d != '0);
    req_ready_d = (count_d < CNT_W'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
      op_count_q  <= '0;
      err_count_q <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= req_ready_d;
      op_count_q  <= op_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign op_count   = op_count_q;
  assign err_count  = err_count_q;
  assign {rsp_err, rsp_ovf, rsp_carry, rsp_zero, rsp_tag, rsp_result} = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: vector table plus random traffic checked through an in-order
// scoreboard, with hand-written backpressure, reset and counter-saturation sequences.
module tb_alu_exec_unit;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [3:0]  tag;
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        v;
    logic        e;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [2:0]  req_op;
  logic [3:0]  req_tag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_carry;
  logic        rsp_ovf;
  logic        rsp_err;
  logic [3:0]  rsp_tag;
  logic [15:0] op_count;
  logic [7:0]  err_count;

  int   n_cmp = 0;
  int   n_err = 0;
  vec_t sb_q[$];
  vec_t cur;
  vec_t tbl[12];
  int   exp_ops = 0;
  int   exp_errs = 0;
  bit   prev_hold = 1'b0;
  logic [39:0] hold_snap;
  bit   rnd_done;

  alu_exec_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
    .rsp_ovf(rsp_ovf), .rsp_err(rsp_err), .rsp_tag(rsp_tag),
    .op_count(op_count), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                              input logic [3:0] tag, input logic [31:0] res,
                              input logic z, input logic c, input logic v, input logic e);
    vec_t r;
    r = '{a: a, b: b, op: op, tag: tag, res: res, z: z, c: c, v: v, e: e};
    return r;
  endfunction

  // Reference model using 64-bit integer arithmetic
  function automatic vec_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] op, input logic [3:0] tag);
    vec_t r;
    longint sa, sbv, sr;
    longint unsigned ua, ub;
    r = '0;
    r.a = a; r.b = b; r.op = op; r.tag = tag;
    sa = longint'($signed(a));
    sbv = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    sr = 0;
    case (op)
      3'd0: begin
        r.res = a + b;
        r.c = (ua + ub) > 64'h0000_0000_FFFF_FFFF;
        sr = sa + sbv;
        r.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      3'd1: begin
        r.res = a - b;
        r.c = (ua < ub);
        sr = sa - sbv;
        r.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      3'd2: r.res = a & b;
      3'd3: r.res = a | b;
      3'd4: r.res = a ^ b;
      3'd5: r.res = ~(a | b);
      default: begin r.res = '0; r.e = 1'b1; end
    endcase
    r.z = (r.res == 32'd0);
    return r;
  endfunction

  // Monitor on the falling edge: records accepts and checks pops that the next rising edge will take
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_hold && rsp_valid)
        check("rsp_hold_stable",
              64'({rsp_result, rsp_tag, rsp_zero, rsp_carry, rsp_ovf, rsp_err}), 64'(hold_snap));
      if (req_valid && req_ready) begin
        sb_q.push_back(cur);
        if (exp_ops < 65535) exp_ops++;
        if (cur.e && exp_errs < 255) exp_errs++;
      end
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rsp_unexpected: got tag %h result %h expected no response", rsp_tag, rsp_result);
        end else begin
          vec_t e;
          e = sb_q.pop_front();
          check("rsp_payload",
                64'({rsp_result, rsp_tag, rsp_zero, rsp_carry, rsp_ovf, rsp_err}),
                64'({e.res, e.tag, e.z, e.c, e.v, e.e}));
        end
      end
      prev_hold = rsp_valid && !rsp_ready;
      hold_snap = {rsp_result, rsp_tag, rsp_zero, rsp_carry, rsp_ovf, rsp_err};
    end else begin
      prev_hold = 1'b0;
    end
  end

  // Present one request and hold it until accepted; returns 1 time unit after the accept edge
  task automatic send(input vec_t v);
    bit ok;
    ok = 1'b0;
    cur = v;
    req_a = v.a; req_b = v.b; req_op = v.op; req_tag = v.tag;
    req_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got req_ready 0 for tag %h expected acceptance within 50 cycles", v.tag);
    end
  endtask

  task automatic send_rand(input int idx);
    logic [31:0] a, b;
    a = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
    b = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
    send(model(a, b, 3'($urandom_range(0, 7)), 4'(idx)));
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (sb_q.size() == 0 && !rsp_valid) break;
      @(posedge clk);
      #1;
    end
    check("drain_empty", 64'(sb_q.size()), 64'd0);
    check("drain_rsp_valid", 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [39:0] snap;

    tbl[0]  = mk(32'hA5A5A5A5, 32'h5A5A5A5A, 3'd0, 4'h1, 32'hFFFFFFFF, 0, 0, 0, 0);
    tbl[1]  = mk(32'hA5A5A5A5, 32'h5A5A5A5A, 3'd1, 4'h2, 32'h4B4B4B4B, 0, 0, 1, 0);
    tbl[2]  = mk(32'hA5A5A5A5, 32'h5A5A5A5A, 3'd2, 4'h3, 32'h00000000, 1, 0, 0, 0);
    tbl[3]  = mk(32'hA5A5A5A5, 32'h5A5A5A5A, 3'd3, 4'h4, 32'hFFFFFFFF, 0, 0, 0, 0);
    tbl[4]  = mk(32'hA5A5A5A5, 32'h5A5A5A5A, 3'd4, 4'h5, 32'hFFFFFFFF, 0, 0, 0, 0);
    tbl[5]  = mk(32'hA5A5A5A5, 32'h5A5A5A5A, 3'd5, 4'h6, 32'h00000000, 1, 0, 0, 0);
    tbl[6]  = mk(32'h00000000, 32'h00000001, 3'd1, 4'h8, 32'hFFFFFFFF, 0, 1, 0, 0);
    tbl[7]  = mk(32'h7FFFFFFF, 32'h00000001, 3'd0, 4'h9, 32'h80000000, 0, 0, 1, 0);
    tbl[8]  = mk(32'h12345678, 32'h00000009, 3'd6, 4'h7, 32'h00000000, 1, 0, 0, 1);
    tbl[9]  = mk(32'hFFFFFFFF, 32'h00000001, 3'd0, 4'hA, 32'h00000000, 1, 1, 0, 0);
    tbl[10] = mk(32'h80000000, 32'h00000001, 3'd1, 4'hB, 32'h7FFFFFFF, 0, 0, 1, 0);
    tbl[11] = mk(32'hDEADBEEF, 32'h00000000, 3'd7, 4'hC, 32'h00000000, 1, 0, 0, 1);

    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_op = '0; req_tag = '0;
    cur = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_data", 64'({rsp_result, rsp_tag, rsp_zero, rsp_carry, rsp_ovf, rsp_err}), 64'd0);
    check("reset_counters", 64'({op_count, err_count}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release_req_ready", 64'(req_ready), 64'd1);

    // Single add: response visible the cycle after the accept edge
    send(tbl[0]);
    check("lat_rsp_valid", 64'(rsp_valid), 64'd1);
    check("lat_rsp_result", 64'(rsp_result), 64'hFFFFFFFF);
    check("lat_rsp_tag", 64'(rsp_tag), 64'h1);
    drain();

    // Remaining table vectors streamed back-to-back with the consumer always ready
    rsp_ready = 1'b1;
    for (int i = 1; i < 12; i++) begin
      send(tbl[i]);
      if (i == 8) check("err_count_first", 64'(err_count), 64'd1);
    end
    drain();
    check("op_count_table", 64'(op_count), 64'd12);
    check("err_count_table", 64'(err_count), 64'd2);

    // Backpressure: two fill the FIFO, third waits until the first pop
    rsp_ready = 1'b0;
    send_rand(1);
    send_rand(2);
    check("full_req_ready", 64'(req_ready), 64'd0);
    snap = {rsp_result, rsp_tag, rsp_zero, rsp_carry, rsp_ovf, rsp_err};
    fork
      send_rand(3);
      begin
        repeat (3) @(posedge clk);
        #1;
        check("bp_stable", 64'({rsp_result, rsp_tag, rsp_zero, rsp_carry, rsp_ovf, rsp_err}), 64'(snap));
        check("bp_req_ready", 64'(req_ready), 64'd0);
        rsp_ready = 1'b1;
      end
    join
    drain();

    // Random traffic under random consumer stalls
    rnd_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 40; k++) send_rand(k);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          rsp_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
    check("op_count_rand", 64'(op_count), 64'(exp_ops));
    check("err_count_rand", 64'(err_count), 64'(exp_errs));

    // Reset with two responses buffered discards them
    rsp_ready = 1'b0;
    send_rand(4);
    send_rand(5);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midrst_counters", 64'({op_count, err_count}), 64'd0);
    sb_q.delete();
    exp_ops = 0;
    exp_errs = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_req_ready", 64'(req_ready), 64'd1);
    check("midrst_rsp_valid_after", 64'(rsp_valid), 64'd0);

    // Illegal ops past the error counter limit
    rsp_ready = 1'b1;
    for (int k = 0; k < 260; k++)
      send(model($urandom, $urandom, 3'(6 + (k % 2)), 4'(k)));
    drain();
    check("err_count_sat", 64'(err_count), 64'd255);
    check("op_count_after_sat", 64'(op_count), 64'd260);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
